// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters,
// with a zero-fill sweep sequenced after reset and on clr_req.
module ram_arbiter #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rst,
    input  logic [DATA_W-1:0] ram_dout
);
    typedef enum logic {S_CLEAR, S_SERVE} state_t;

    localparam state_t              RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_SERVE;
    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              prio_q;      // 1 = port 1 preferred on a tie
    logic              rsp0_q, rsp1_q;

    logic clearing, serving, gnt0, gnt1;

    // Outputs are gated by rst_n so they sit idle for the whole reset pulse,
    // even though the state register already holds the post-release state.
    always_comb begin
        clearing = rst_n && (state_q == S_CLEAR);
        serving  = rst_n && (state_q == S_SERVE) && !clr_req;
        gnt0     = serving && req0_valid && (!req1_valid || !prio_q);
        gnt1     = serving && req1_valid && (!req0_valid ||  prio_q);
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (clearing) begin
            ram_we   = 1'b1;
            ram_addr = cnt_q;
        end else if (gnt0) begin
            ram_we   = req0_we;
            ram_addr = req0_addr;
            ram_din  = req0_wdata;
        end else if (gnt1) begin
            ram_we   = req1_we;
            ram_addr = req1_addr;
            ram_din  = req1_wdata;
        end
    end

    assign busy       = clearing;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp0_rdata = ram_dout;
    assign rsp1_rdata = ram_dout;
    assign ram_rst    = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
        end else begin
            rsp0_q <= gnt0 && !req0_we;
            rsp1_q <= gnt1 && !req1_we;
            if (gnt0) prio_q <= 1'b1;
            if (gnt1) prio_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        cnt_q   <= '0;
                        state_q <= S_SERVE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (clr_req) state_q <= S_CLEAR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural read-first 16x8 RAM.
module tb_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_req;
    logic       busy;
    logic       req0_valid, req0_ready, req0_we, rsp0_valid;
    logic [3:0] req0_addr;
    logic [7:0] req0_wdata, rsp0_rdata;
    logic       req1_valid, req1_ready, req1_we, rsp1_valid;
    logic [3:0] req1_addr;
    logic [7:0] req1_wdata, rsp1_rdata;
    logic       ram_we, ram_rst;
    logic [3:0] ram_addr;
    logic [7:0] ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rst) ram_dout <= 8'h00;
        else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_rst(ram_rst), .ram_dout(ram_dout)
    );

    task automatic idle();
        clr_req = 0;
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        req0_valid = 1; req1_valid = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, ram_we, ram_addr, ram_din, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b we=%b addr=%0d din=%h rdy=%b%b rsp=%b%b required all 0",
                     busy, ram_we, ram_addr, ram_din, req0_ready, req1_ready, rsp0_valid, rsp1_valid);
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (busy !== 1 || ram_we !== 1 || ram_addr !== 4'(i) || ram_din !== 8'h00 ||
                req0_ready !== 0 || req1_ready !== 0) begin
                errors++;
                $display("FAIL reset_sweep[%0d] busy=%b we=%b addr=%0d din=%h rdy=%b%b required 1 1 %0d 00 00",
                         i, busy, ram_we, ram_addr, ram_din, req0_ready, req1_ready, i);
            end
            @(negedge clk);
        end
        idle();
        #1;
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL reset_sweep_end busy=%b required 0", busy);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req0_valid = 1; req0_we = 1; req0_addr = 3; req0_wdata = 8'hA5;
        #1;
        checks++;
        if (req0_ready !== 1 || ram_we !== 1 || ram_addr !== 3 || ram_din !== 8'hA5) begin
            errors++;
            $display("FAIL wr_grant rdy=%b we=%b addr=%0d din=%h required 1 1 3 a5", req0_ready, ram_we, ram_addr, ram_din);
        end
        @(negedge clk);
        req0_we = 0;
        #1;
        checks++;
        if (req0_ready !== 1 || ram_we !== 0 || rsp0_valid !== 0) begin
            errors++;
            $display("FAIL rd_grant rdy=%b we=%b rsp0=%b required 1 0 0", req0_ready, ram_we, rsp0_valid);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rsp0_valid !== 1 || rsp0_rdata !== 8'hA5 || rsp1_valid !== 0) begin
            errors++;
            $display("FAIL rd_rsp rsp0=%b data=%h rsp1=%b required 1 a5 0", rsp0_valid, rsp0_rdata, rsp1_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp0_valid !== 0) begin
            errors++;
            $display("FAIL rd_rsp_one_cycle rsp0=%b required 0", rsp0_valid);
        end
    endtask

    task automatic test_clear_req();
        @(negedge clk);
        req1_valid = 1; req1_we = 1; req1_addr = 15; req1_wdata = 8'h3C;
        #1;
        checks++;
        if (req1_ready !== 1 || ram_we !== 1 || ram_addr !== 15) begin
            errors++;
            $display("FAIL clr_prewrite rdy1=%b we=%b addr=%0d required 1 1 15", req1_ready, ram_we, ram_addr);
        end
        @(negedge clk);
        req1_we = 0; req0_valid = 1; clr_req = 1;
        #1;
        checks++;
        if (req0_ready !== 0 || req1_ready !== 0 || ram_we !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL clr_no_grant rdy=%b%b we=%b busy=%b required 00 0 0", req0_ready, req1_ready, ram_we, busy);
        end
        @(negedge clk);
        idle();
        for (int i = 0; i < 16; i++) begin
            clr_req = (i == 5);
            #1;
            checks++;
            if (busy !== 1 || ram_we !== 1 || ram_addr !== 4'(i) || ram_din !== 8'h00) begin
                errors++;
                $display("FAIL clr_sweep[%0d] busy=%b we=%b addr=%0d din=%h required 1 1 %0d 00",
                         i, busy, ram_we, ram_addr, ram_din, i);
            end
            @(negedge clk);
        end
        clr_req = 0;
        req0_valid = 1; req0_addr = 15;
        #1;
        checks++;
        if (busy !== 0 || req0_ready !== 1) begin
            errors++;
            $display("FAIL clr_end busy=%b rdy0=%b required 0 1", busy, req0_ready);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rsp0_valid !== 1 || rsp0_rdata !== 8'h00) begin
            errors++;
            $display("FAIL clr_readback rsp0=%b data=%h required 1 00", rsp0_valid, rsp0_rdata);
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        req1_valid = 1; req1_we = 1; req1_addr = 1; req1_wdata = 8'h11;
        @(negedge clk);
        req1_addr = 2; req1_wdata = 8'h22;
        @(negedge clk);
        req0_valid = 1; req0_we = 0; req0_addr = 1;
        req1_valid = 1; req1_we = 0; req1_addr = 2;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL rr_grant[%0d] rdy=%b%b required %b%b", k, req0_ready, req1_ready,
                         k % 2 == 0, k % 2 == 1);
            end
            if (k > 0) begin
                checks++;
                if (rsp0_valid !== (k % 2 == 1) || rsp1_valid !== (k % 2 == 0) ||
                    ram_dout !== ((k % 2 == 1) ? 8'h11 : 8'h22)) begin
                    errors++;
                    $display("FAIL rr_rsp[%0d] rsp=%b%b data=%h", k, rsp0_valid, rsp1_valid, rsp0_rdata);
                end
            end
            @(negedge clk);
        end
        idle();
        #1;
        checks++;
        if (rsp1_valid !== 1 || rsp0_valid !== 0 || rsp1_rdata !== 8'h22) begin
            errors++;
            $display("FAIL rr_last_rsp rsp=%b%b data=%h required 01 22", rsp0_valid, rsp1_valid, rsp1_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        req0_valid = 1; req0_we = 0; req0_addr = 2;
        @(posedge clk);
        #1;
        rst_n = 0;
        idle();
        #1;
        checks++;
        if (rsp0_valid !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL rst_mid_rsp rsp0=%b busy=%b required 0 0", rsp0_valid, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rsp0_valid !== 0) begin
            errors++;
            $display("FAIL rst_mid_hold rsp0=%b required 0", rsp0_valid);
        end
        rst_n = 1;
        #1;
        checks++;
        if (busy !== 1 || ram_we !== 1 || ram_addr !== 0 || rsp0_valid !== 0) begin
            errors++;
            $display("FAIL rst_mid_sweep busy=%b we=%b addr=%0d rsp0=%b required 1 1 0 0",
                     busy, ram_we, ram_addr, rsp0_valid);
        end
        repeat (16) @(negedge clk);
        #1;
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL rst_mid_sweep_end busy=%b required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req0_valid = 1; req0_we = 1; req0_addr = 7; req0_wdata = 8'h5A;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (req0_ready !== 1 || req1_ready !== 0 || ram_addr !== 7 || ram_we !== (k == 0)) begin
                errors++;
                $display("FAIL b2b_grant[%0d] rdy=%b%b addr=%0d we=%b", k, req0_ready, req1_ready, ram_addr, ram_we);
            end
            checks++;
            if (rsp0_valid !== (k >= 2) || (k >= 2 && rsp0_rdata !== 8'h5A)) begin
                errors++;
                $display("FAIL b2b_rsp[%0d] rsp0=%b data=%h required %b 5a", k, rsp0_valid, rsp0_rdata, k >= 2);
            end
            @(negedge clk);
            req0_we = 0;
        end
        idle();
        #1;
        checks++;
        if (rsp0_valid !== 1 || rsp0_rdata !== 8'h5A || rsp1_valid !== 0) begin
            errors++;
            $display("FAIL b2b_last rsp0=%b data=%h rsp1=%b required 1 5a 0", rsp0_valid, rsp0_rdata, rsp1_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_clear_req();
        test_round_robin();
        test_reset_mid_read();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin controller that shares the single-port 16x8 RAM between two requesters (port 0, port 1).
- Sequences a zero-fill of the whole array after reset and on demand.
- Sits between the requesters and the RAM's we/addr/datain/dataout pins.
- Holds the RAM's own synchronous reset inactive; clearing is done by write sweeps.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 16, number of RAM words; must equal 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = run a zero-fill sweep after reset release; 0 = go straight to SERVE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr_req  in  1  one-cycle pulse that requests a zero-fill sweep.
- busy  out  1  high while a sweep is in progress.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_we  in  1  port 0: 1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- rsp0_valid  out  1  port 0 read data valid.
- rsp0_rdata  out  DATA_W  port 0 read data.
- req1_* / rsp1_*  same set, same widths  port 1 request and response.
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_din  out  DATA_W  to RAM datain.
- ram_rst  out  1  to RAM rst; tied 0.
- ram_dout  in  DATA_W  from RAM dataout.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs held at: reqN_ready=0, rspN_valid=0, busy=0, ram_we=0, ram_addr=0, ram_din=0.
  - Round-robin pointer = "port 0 preferred"; sweep counter = 0.
  - State after release: CLEAR if CLEAR_ON_RESET=1, else SERVE.
- Reset asserted mid-sweep or mid-transaction: the operation is abandoned. An outstanding read response is dropped, with rspN_valid forced to 0 immediately.
- FSM has two states, CLEAR and SERVE.
- CLEAR:
  - busy=1, ram_we=1, ram_din=0, ram_addr=counter, both readies 0.
  - Counter increments 0 to DEPTH-1, one word per cycle.
  - After the cycle writing DEPTH-1, go to SERVE and clear the counter.
  - Sweep lasts exactly DEPTH cycles. clr_req is ignored during CLEAR.
- SERVE, clr_req=1:
  - No grant that cycle; both readies 0; ram_we=0.
  - Next state is CLEAR. clr_req takes priority over pending requests.
- SERVE, request grant:
  - One valid request: grant it.
  - Both valid: grant the port not granted last. The pointer updates only on a grant.
  - reqN_ready is combinational: high for the granted port only.
  - A transfer occurs when valid && ready. Requesters hold all req fields stable until accepted.
- RAM drive in SERVE (combinational from the granted request):
  - ram_we = req_we, ram_addr = req_addr, ram_din = req_wdata.
  - With no grant: ram_we=0, ram_addr=0, ram_din=0.
- Read latency:
  - rspN_valid is registered and goes high exactly one cycle after a read is accepted on port N, for one cycle.
  - rspN_rdata = ram_dout, combinational pass-through. It is only meaningful while rspN_valid=1.
- Writes generate no response.
- Throughput: one transfer per cycle. Back-to-back reads on alternating ports give one rsp per cycle.
- Write then read of the same address in consecutive cycles returns the new data.

Test Plan:
- Reset, then release with CLEAR_ON_RESET=1 → busy=1 for exactly 16 cycles; ram_we=1 with ram_addr 0..15 and ram_din=0; readies 0; then busy=0.
- Port0 writes 0xA5 to addr 3, then reads addr 3 → ready0=1 on each; rsp0_valid one cycle after the read with rsp0_rdata=0xA5; rsp1_valid stays 0.
- Both ports valid continuously, reading addr 1 and 2 → grants alternate 0,1,0,1 (port 0 first after reset); each rsp arrives one cycle after its grant with the correct data.
- Port1 writes 0x3C to addr 15, then clr_req with both ports valid → no grant that cycle; 16-cycle sweep; a later read of addr 15 returns 0x00.
- rst_n dropped one cycle after a port0 read is accepted → rsp0_valid forced to 0 immediately and never asserted; after release, a fresh sweep starts at addr 0.
- Port0 continuously valid while port1 idle → port0 granted every cycle, no bubbles.
